bus_arb_2a1: RTL

BUS_ARB_2A1 -- requirements
Module: bus_arb_2a1

---
 rtl/arb_pkg.sv | 17 +
 rtl/mux_2a1.sv | 17 +
 rtl/bus_arb_2a1.sv | 131 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester bus arbiter.
package arb_pkg;

  localparam int unsigned DATA_W_DEF = 33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/mux_2a1.sv
// 2:1 data steering mux; sel = 0 picks a_i, sel = 1 picks b_i.
module mux_2a1
  import arb_pkg::*;
#(
  parameter int unsigned W = DATA_W_DEF
) (
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = sel_i ? b_i : a_i;
  end

endmodule

// File: rtl/bus_arb_2a1.sv
// Round-robin bus arbiter for two requesters with a per-grant burst limit
// that only hands over when the other side is actually waiting.
module bus_arb_2a1
  import arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_a_i,
  input  logic              req_b_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              ready_i,
  output logic              gnt_a_o,
  output logic              gnt_b_o,
  output logic              sel_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] sal_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_id_e          last_q, last_d;
  logic             sel_q, sel_d;
  logic             init_q, init_d;
  logic             xfer;
  logic             limit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= ID_B;
      sel_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      init_q  <= init_d;
    end
  end

  // limit fires on the transfer that completes the MAX_BURST-th word, so the
  // counter itself only ever holds 0..MAX_BURST-1.
  always_comb begin
    xfer  = valid_o & ready_i;
    limit = xfer && (cnt_q == CNT_W'(MAX_BURST - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    init_d  = 1'b1;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // First edge after reset release only arms the arbiter.
        if (init_q) begin
          if (req_a_i && (!req_b_i || last_q == ID_B)) begin
            state_d = GNT_A;
            sel_d   = 1'b0;
          end else if (req_b_i) begin
            state_d = GNT_B;
            sel_d   = 1'b1;
          end
        end
      end
      GNT_A: begin
        sel_d = 1'b0;
        if (!req_a_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = ID_A;
        end else if (limit) begin
          cnt_d = '0;
          if (req_b_i) begin
            state_d = GNT_B;
            sel_d   = 1'b1;
            last_d  = ID_A;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GNT_B: begin
        sel_d = 1'b1;
        if (!req_b_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = ID_B;
        end else if (limit) begin
          cnt_d = '0;
          if (req_a_i) begin
            state_d = GNT_A;
            sel_d   = 1'b0;
            last_d  = ID_B;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    gnt_a_o = (state_q == GNT_A);
    gnt_b_o = (state_q == GNT_B);
    sel_o   = sel_q;
    valid_o = (gnt_a_o & req_a_i) | (gnt_b_o & req_b_i);
  end

  mux_2a1 #(.W(DATA_W)) u_mux (
    .sel_i (sel_q),
    .a_i   (a_i),
    .b_i   (b_i),
    .y_o   (sal_o)
  );

endmodule
